// File: rtl/cpu_pkg.sv
// Shared pipeline-control types: PC mux select codes, sequencer states and
// register-select width.
package cpu_pkg;

    localparam int unsigned REG_SEL_W = 4;

    typedef logic [1:0] pc_sel_t;
    localparam pc_sel_t PC_SEQ    = 2'b00;
    localparam pc_sel_t PC_BRANCH = 2'b01;
    localparam pc_sel_t PC_VECTOR = 2'b10;
    localparam pc_sel_t PC_EPC    = 2'b11;

    typedef logic [1:0] ctrl_state_t;
    localparam ctrl_state_t RUN    = 2'd0;
    localparam ctrl_state_t DRAIN  = 2'd1;
    localparam ctrl_state_t VECTOR = 2'd2;
    localparam ctrl_state_t ISR    = 2'd3;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between a pending load in execute and the
// operands read by the instruction in decode. Purely combinational.
module hazard_detect
    import cpu_pkg::*;
(
    input  logic                 ex_mem_rd,
    input  logic [REG_SEL_W-1:0] ex_reg_dst,
    input  logic                 id_valid,
    input  logic [REG_SEL_W-1:0] id_rs1,
    input  logic [REG_SEL_W-1:0] id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    output logic                 load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_uses_rs1 & (id_rs1 == ex_reg_dst);
    assign rs2_hit  = id_uses_rs2 & (id_rs2 == ex_reg_dst);
    assign load_use = ex_mem_rd & id_valid & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and interrupt sequencer: advance/stall/flush decisions, next-PC
// source select, and the interrupt entry (drain, vector) and return sequence.
module pipeline_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter logic [31:0] INT_VECTOR   = 32'h0000_0004,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_SEL_W-1:0] id_rs1,
    input  logic [REG_SEL_W-1:0] id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic                 id_branch,
    input  logic                 id_returni,
    input  logic [31:0]          id_pc_plus_4,
    input  logic                 ex_mem_rd,
    input  logic [REG_SEL_W-1:0] ex_reg_dst,
    input  logic                 mem_busy,
    input  logic                 int_req,
    output logic                 pc_stall,
    output logic                 if_id_stall,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic [1:0]           pc_sel,
    output logic [31:0]          epc,
    output logic                 int_ack,
    output logic                 in_isr,
    output logic [CNT_W-1:0]     stall_count
);

    localparam int unsigned         DRAIN_W    = 4;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    // The vector address itself is muxed in fetch; only its alignment matters here.
    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15 || INT_VECTOR[1:0] != 2'b00) begin : g_param_check
        $error("pipeline_ctrl: DRAIN_CYCLES out of 1..15 or INT_VECTOR not word aligned");
    end

    ctrl_state_t        state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [31:0]        epc_q;
    logic [CNT_W-1:0]   stall_count_q;
    logic               epc_load;
    logic               load_use;

    hazard_detect u_hazard_detect (
        .ex_mem_rd   (ex_mem_rd),
        .ex_reg_dst  (ex_reg_dst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .load_use    (load_use)
    );

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        epc_load    = 1'b0;
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pc_sel      = PC_SEQ;
        int_ack     = 1'b0;

        if (rst) begin
            // outputs held at zero while reset is asserted
        end else if (mem_busy) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
        end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    // Entry squashes decode; it re-executes from epc after return.
                    if (int_req && id_valid) begin
                        pc_stall    = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        epc_load    = 1'b1;
                        drain_d     = DRAIN_LOAD;
                        state_d     = DRAIN;
                    end else if (id_branch && id_valid) begin
                        pc_sel      = PC_BRANCH;
                        if_id_flush = 1'b1;
                    end
                end
                DRAIN: begin
                    pc_stall    = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (drain_q == '0) begin
                        state_d = VECTOR;
                    end else begin
                        drain_d = drain_q - DRAIN_W'(1);
                    end
                end
                VECTOR: begin
                    pc_sel      = PC_VECTOR;
                    int_ack     = 1'b1;
                    if_id_flush = 1'b1;
                    state_d     = ISR;
                end
                ISR: begin
                    if (id_returni && id_valid) begin
                        pc_sel      = PC_EPC;
                        if_id_flush = 1'b1;
                        state_d     = RUN;
                    end else if (id_branch && id_valid) begin
                        pc_sel      = PC_BRANCH;
                        if_id_flush = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            drain_q       <= '0;
            epc_q         <= '0;
            stall_count_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            if (epc_load) begin
                epc_q <= id_pc_plus_4 - 32'd4;
            end
            if (pc_stall && (stall_count_q != '1)) begin
                stall_count_q <= stall_count_q + CNT_W'(1);
            end
        end
    end

    assign epc         = epc_q;
    assign in_isr      = (state_q == ISR);
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, directed interrupt
// sequences, and random stimulus against a cycle-position reference model.
module tb_pipeline_ctrl;

    localparam int DRAIN   = 3;
    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    // {pc_stall, if_id_stall, if_id_flush, id_ex_flush, pc_sel[1:0], int_ack}
    localparam logic [6:0] O_NONE  = 7'b0000_00_0;
    localparam logic [6:0] O_BUSY  = 7'b1100_00_0;
    localparam logic [6:0] O_LU    = 7'b1101_00_0;
    localparam logic [6:0] O_DRAIN = 7'b1011_00_0;
    localparam logic [6:0] O_VEC   = 7'b0010_10_1;
    localparam logic [6:0] O_RET   = 7'b0010_11_0;
    localparam logic [6:0] O_BR    = 7'b0010_01_0;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_uses_rs1, id_uses_rs2, id_branch, id_returni;
    logic [3:0]    id_rs1, id_rs2, ex_reg_dst;
    logic [31:0]   id_pc_plus_4;
    logic          ex_mem_rd, mem_busy, int_req;
    logic          pc_stall, if_id_stall, if_id_flush, id_ex_flush, int_ack, in_isr;
    logic [1:0]    pc_sel;
    logic [31:0]   epc;
    logic [CW-1:0] stall_count;
    logic [6:0]    outs;

    assign outs = {pc_stall, if_id_stall, if_id_flush, id_ex_flush, pc_sel, int_ack};

    pipeline_ctrl #(
        .DRAIN_CYCLES (DRAIN),
        .INT_VECTOR   (32'h0000_0004),
        .CNT_W        (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .id_branch    (id_branch),
        .id_returni   (id_returni),
        .id_pc_plus_4 (id_pc_plus_4),
        .ex_mem_rd    (ex_mem_rd),
        .ex_reg_dst   (ex_reg_dst),
        .mem_busy     (mem_busy),
        .int_req      (int_req),
        .pc_stall     (pc_stall),
        .if_id_stall  (if_id_stall),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .pc_sel       (pc_sel),
        .epc          (epc),
        .int_ack      (int_ack),
        .in_isr       (in_isr),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model: position within the entry sequence (1..DRAIN drain, DRAIN+1 vector).
    int          m_pos;
    bit          m_isr;
    logic [31:0] m_epc;
    int          m_cnt;

    typedef struct packed {
        logic       mb;
        logic       lr;
        logic [3:0] dst;
        logic       v;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic       u1;
        logic       u2;
        logic       br;
        logic       ret;
        logic [6:0] want;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_branch = 0; id_returni = 0;
        id_rs1 = 0; id_rs2 = 0; ex_reg_dst = 0; id_pc_plus_4 = 0;
        ex_mem_rd = 0; mem_busy = 0; int_req = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        next_cycle();
        next_cycle();
        rst = 0;
        m_pos = 0; m_isr = 0; m_epc = 0; m_cnt = 0;
    endtask

    task automatic model(output logic [6:0] e);
        bit lu;
        lu = ex_mem_rd && id_valid &&
             ((id_uses_rs1 && id_rs1 == ex_reg_dst) || (id_uses_rs2 && id_rs2 == ex_reg_dst));
        e = O_NONE;
        if (mem_busy) e = O_BUSY;
        else if (lu) e = O_LU;
        else if (m_pos >= 1 && m_pos <= DRAIN) begin e = O_DRAIN; m_pos++; end
        else if (m_pos == DRAIN + 1) begin e = O_VEC; m_pos = 0; m_isr = 1; end
        else if (!m_isr && int_req && id_valid) begin
            e = O_DRAIN; m_epc = id_pc_plus_4 - 32'd4; m_pos = 1;
        end
        else if (m_isr && id_returni && id_valid) begin e = O_RET; m_isr = 0; end
        else if (id_branch && id_valid) e = O_BR;
        if (e[6] && m_cnt < CNT_MAX) m_cnt++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] e;
        logic [31:0] pc4;

        vecs[0]  = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
        vecs[1]  = '{1'b0, 1'b1, 4'd5, 1'b1, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[2]  = '{1'b0, 1'b0, 4'd5, 1'b1, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE};
        vecs[3]  = '{1'b0, 1'b1, 4'd7, 1'b1, 4'd2, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0, O_LU};
        vecs[4]  = '{1'b0, 1'b1, 4'd5, 1'b1, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
        vecs[5]  = '{1'b0, 1'b1, 4'd5, 1'b0, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE};
        vecs[6]  = '{1'b0, 1'b0, 4'd0, 1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, O_BR};
        vecs[7]  = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_NONE};
        vecs[8]  = '{1'b0, 1'b1, 4'd3, 1'b1, 4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, O_LU};
        vecs[9]  = '{1'b1, 1'b1, 4'd3, 1'b1, 4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, O_BUSY};
        vecs[10] = '{1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_BUSY};
        vecs[11] = '{1'b0, 1'b0, 4'd0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_NONE};

        // Reset state
        do_reset();
        #1;
        chk("reset outs", 64'(outs), 64'(O_NONE));
        chk("reset epc", 64'(epc), 64'd0);
        chk("reset stall_count", 64'(stall_count), 64'd0);
        chk("reset in_isr", 64'(in_isr), 64'd0);

        // Combinational decisions in RUN
        for (int i = 0; i < 12; i++) begin
            mem_busy = vecs[i].mb; ex_mem_rd = vecs[i].lr; ex_reg_dst = vecs[i].dst;
            id_valid = vecs[i].v; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
            id_branch = vecs[i].br; id_returni = vecs[i].ret; int_req = 0;
            #1;
            chk($sformatf("vec%0d outs", i), 64'(outs), 64'(vecs[i].want));
            next_cycle();
        end

        // Interrupt entry, drain, vector, ISR, return with re-entry
        do_reset();
        id_valid = 1; id_pc_plus_4 = 32'h0000_0108; int_req = 1;
        #1;
        chk("entry outs", 64'(outs), 64'(O_DRAIN));
        next_cycle();
        id_valid = 0;
        #1;
        chk("entry epc", 64'(epc), 64'h104);
        for (int i = 0; i < DRAIN; i++) begin
            chk($sformatf("drain%0d outs", i), 64'(outs), 64'(O_DRAIN));
            next_cycle();
            #1;
        end
        chk("vector outs", 64'(outs), 64'(O_VEC));
        chk("vector in_isr", 64'(in_isr), 64'd0);
        next_cycle();
        #1;
        chk("isr in_isr", 64'(in_isr), 64'd1);
        chk("isr idle outs", 64'(outs), 64'(O_NONE));
        id_valid = 1; id_pc_plus_4 = 32'h0000_0300;
        #1;
        chk("isr no nesting", 64'(outs), 64'(O_NONE));
        next_cycle();
        #1;
        chk("isr epc hold", 64'(epc), 64'h104);
        id_returni = 1; id_branch = 1;
        #1;
        chk("return over branch", 64'(outs), 64'(O_RET));
        next_cycle();
        id_returni = 0; id_branch = 0; id_pc_plus_4 = 32'h0000_0200;
        #1;
        chk("return in_isr drop", 64'(in_isr), 64'd0);
        chk("reentry outs", 64'(outs), 64'(O_DRAIN));
        next_cycle();
        int_req = 0; id_valid = 0;
        #1;
        chk("reentry epc", 64'(epc), 64'h1FC);

        // mem_busy during DRAIN delays the vector by exactly the busy cycles
        do_reset();
        id_valid = 1; id_pc_plus_4 = 32'h0000_0040; int_req = 1;
        next_cycle();
        idle_inputs();
        #1;
        chk("busy drain first", 64'(outs), 64'(O_DRAIN));
        next_cycle();
        mem_busy = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("busy freeze%0d", i), 64'(outs), 64'(O_BUSY));
            next_cycle();
        end
        mem_busy = 0;
        for (int i = 0; i < DRAIN - 1; i++) begin
            #1;
            chk($sformatf("busy drain rest%0d", i), 64'(outs), 64'(O_DRAIN));
            next_cycle();
        end
        #1;
        chk("busy vector", 64'(outs), 64'(O_VEC));
        chk("busy stall_count", 64'(stall_count), 64'd8);

        // Asynchronous reset in the middle of DRAIN
        do_reset();
        id_valid = 1; id_pc_plus_4 = 32'h0000_0080; int_req = 1;
        next_cycle();
        idle_inputs();
        #1;
        chk("pre-reset drain", 64'(outs), 64'(O_DRAIN));
        chk("pre-reset epc", 64'(epc), 64'h7C);
        #2;
        rst = 1;
        #1;
        chk("async rst outs", 64'(outs), 64'(O_NONE));
        chk("async rst epc", 64'(epc), 64'd0);
        chk("async rst in_isr", 64'(in_isr), 64'd0);
        chk("async rst stall_count", 64'(stall_count), 64'd0);
        next_cycle();
        rst = 0; id_valid = 1; id_branch = 1;
        #1;
        chk("post-reset run branch", 64'(outs), 64'(O_BR));

        // Stall counter saturation
        do_reset();
        mem_busy = 1;
        for (int i = 0; i < 10; i++) next_cycle();
        chk("stall_count 10", 64'(stall_count), 64'd10);
        for (int i = 0; i < CNT_MAX + 6; i++) next_cycle();
        chk("stall_count saturated", 64'(stall_count), 64'(CNT_MAX));
        next_cycle();
        chk("stall_count held", 64'(stall_count), 64'(CNT_MAX));

        // Random stimulus against the reference model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            mem_busy     = ($urandom_range(0, 9) == 0);
            ex_mem_rd    = ($urandom_range(0, 2) == 0);
            ex_reg_dst   = 4'($urandom_range(0, 3));
            id_rs1       = 4'($urandom_range(0, 3));
            id_rs2       = 4'($urandom_range(0, 3));
            id_uses_rs1  = ($urandom_range(0, 1) == 0);
            id_uses_rs2  = ($urandom_range(0, 1) == 0);
            id_valid     = ($urandom_range(0, 3) != 0);
            id_branch    = ($urandom_range(0, 4) == 0);
            id_returni   = ($urandom_range(0, 7) == 0);
            int_req      = ($urandom_range(0, 4) == 0);
            pc4          = $urandom();
            pc4[1:0]     = 2'b00;
            id_pc_plus_4 = pc4;
            #1;
            chk($sformatf("rand%0d epc", n), 64'(epc), 64'(m_epc));
            chk($sformatf("rand%0d stall_count", n), 64'(stall_count), 64'(m_cnt));
            chk($sformatf("rand%0d in_isr", n), 64'(in_isr), 64'(m_isr));
            model(e);
            chk($sformatf("rand%0d outs", n), 64'(outs), 64'(e));
            next_cycle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Hazard and interrupt sequencer for the five-stage pipeline. It watches the decode stage (operand selects, branch and return decode) and the execute stage (pending load destination), and decides each cycle whether to advance, stall or flush. It selects the next-PC source and runs the interrupt entry and return sequence. Outputs drive the PC register, the IF/ID and ID/EX buffers, and the fetch-stage PC mux.

Parameters:
DRAIN_CYCLES, 3, number of cycles to flush fetch before vectoring (1..15)
INT_VECTOR, 32'h0000_0004, interrupt service routine entry address
CNT_W, 16, width of the stall-cycle performance counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  IF/ID holds a real instruction (not a bubble)
id_rs1  in  4  decode source register 1 select
id_rs2  in  4  decode source register 2 select
id_uses_rs1  in  1  decode instruction reads rs1
id_uses_rs2  in  1  decode instruction reads rs2
id_branch  in  1  decode resolved a taken branch/jump/call
id_returni  in  1  decode holds a return-from-interrupt
id_pc_plus_4  in  32  PC+4 of the decode instruction
ex_mem_rd  in  1  execute-stage instruction is a load
ex_reg_dst  in  4  execute-stage destination register
mem_busy  in  1  memory stage not ready; freeze whole front end
int_req  in  1  level interrupt request
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID buffer
if_id_flush  out  1  load bubble into IF/ID
id_ex_flush  out  1  load bubble into ID/EX
pc_sel  out  2  00 sequential, 01 branch target, 10 INT_VECTOR, 11 epc
epc  out  32  saved return address
int_ack  out  1  one-cycle pulse on vector fetch
in_isr  out  1  high while servicing an interrupt
stall_count  out  CNT_W  saturating count of cycles with pc_stall=1

Behaviour:
- Reset (async, rst=1): state=RUN, epc=0, stall_count=0. All outputs are 0, which makes pc_sel=00.
- Outputs are combinational from state plus inputs. State, epc, the drain counter and stall_count are registered.
- load_use = ex_mem_rd & id_valid & ((id_uses_rs1 & id_rs1==ex_reg_dst) | (id_uses_rs2 & id_rs2==ex_reg_dst)).
- Priority each cycle, highest first: mem_busy, load_use, FSM action, branch.
- mem_busy=1: pc_stall=1 and if_id_stall=1. No flush. pc_sel=00. FSM and drain counter frozen. No epc capture.
- load_use (mem_busy=0): pc_stall=1, if_id_stall=1, id_ex_flush=1. Branch and interrupt are suppressed this cycle. There is exactly one bubble per load-use; the next cycle re-evaluates.
- Branch (RUN or ISR, no higher event): id_branch & id_valid gives pc_sel=01 and if_id_flush=1.
- FSM states: RUN, DRAIN, VECTOR, ISR.
- RUN, interrupt entry:
  - Condition: int_req & id_valid, with no mem_busy and no load_use.
  - Actions: epc <= id_pc_plus_4 - 4, if_id_flush=1, id_ex_flush=1, pc_stall=1, drain counter <= DRAIN_CYCLES-1, next state DRAIN.
  - The decode instruction is squashed and re-executed after return, including a branch in decode.
  - int_req with id_valid=0 is deferred until a valid instruction reaches decode.
- DRAIN: pc_stall=1, if_id_flush=1, id_ex_flush=1. Counter decrements. At 0 the next state is VECTOR.
- VECTOR (one cycle): pc_sel=10, int_ack=1, if_id_flush=1. Next state ISR.
- ISR:
  - in_isr=1. int_req is ignored (no nesting). Normal hazard and branch handling applies.
  - Return condition: id_returni & id_valid, with no mem_busy and no load_use.
  - Return actions: pc_sel=11, if_id_flush=1, next state RUN. Return takes priority over a simultaneous branch.
  - int_req still high at return is taken in RUN on the first eligible cycle.
- epc changes only on interrupt entry. It holds through ISR.
- stall_count increments on every cycle with pc_stall=1 and saturates at all-ones (no wrap).
- Reset mid-sequence (DRAIN/VECTOR/ISR) returns the FSM to RUN and clears epc and in_isr.

Decomposition:
- Shared package cpu_pkg holds:
  - typedef pc_sel_t (PC_SEQ, PC_BRANCH, PC_VECTOR, PC_EPC);
  - typedef ctrl_state_t (RUN, DRAIN, VECTOR, ISR);
  - register-select width constant REG_SEL_W=4.
- One sub-module, hazard_detect: purely combinational load_use compare, reusable by the forwarding unit.

Test Plan:
- Load-use: ex_mem_rd=1, ex_reg_dst=5, id_rs1=5, id_uses_rs1=1, id_valid=1 -> one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1. Next cycle all 0 once ex_mem_rd drops.
- No false stall: same as above but id_uses_rs1=0, id_rs2=5, id_uses_rs2=0 -> no stall. Also id_branch=1 with no hazard -> pc_sel=01, if_id_flush=1 for 1 cycle.
- Interrupt entry: RUN, id_pc_plus_4=32'h0000_0108, int_req=1 -> epc=32'h0000_0104. Then 3 DRAIN cycles, then VECTOR with pc_sel=10 and int_ack=1 for exactly 1 cycle, then in_isr=1.
- Return: in ISR, id_returni=1 together with id_branch=1 -> pc_sel=11 (not 01), in_isr drops next cycle. int_req held high throughout -> re-entry begins the first cycle in RUN.
- mem_busy during DRAIN for 4 cycles -> drain counter frozen, VECTOR delayed by exactly 4 cycles. stall_count includes those cycles.
- Async reset asserted mid-DRAIN, off clock edge -> outputs 0, epc=0, state RUN immediately. Separately, force stall_count to all-ones -> it stays all-ones.
